// File: rtl/three_phase_pwm_pkg.sv
// Shared definitions for the three-phase centre-aligned PWM block.
// Sample format, phase indices, default carrier/dead-time sizing and the
// 2's-complement to offset-binary helper used for the duty comparison.
package three_phase_pwm_pkg;

    localparam int SAMPLE_W      = 19;
    localparam int NUM_PHASES    = 3;
    localparam int U             = 0;
    localparam int V             = 1;
    localparam int W             = 2;

    localparam int CNT_W_DEFAULT = 10;
    localparam int DEAD_DEFAULT  = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Flipping the sign bit maps [-1,1) onto 0..2^SAMPLE_W-1 monotonically,
    // so -1.0 becomes 0 (never on) and just-below +1.0 becomes all ones.
    function automatic logic [SAMPLE_W-1:0] to_offset(input sample_t s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/three_phase_pwm_deadtime.sv
// Per-phase dead-time inserter for one half-bridge leg.
// Any change of the raw PWM level, a disabled cycle, or the first enabled
// cycle after a disable restarts the dead counter; the gates follow raw only
// once the counter has run down, so H and L can never overlap.
module pwm_deadtime #(
    parameter int DEAD = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Enable,
    input  logic raw,
    output logic H,
    output logic L
);

    localparam logic [7:0] DEAD_V = 8'(DEAD);

    logic [7:0] dcnt;
    logic [7:0] dcnt_nxt;
    logic       raw_q;
    logic       en_q;
    logic       reload;
    logic       drive;

    // Reload on any event that makes the leg state uncertain; otherwise run down.
    always_comb begin
        reload   = !Enable || !en_q || (raw != raw_q);
        dcnt_nxt = dcnt;
        if (reload)
            dcnt_nxt = DEAD_V;
        else if (dcnt != 8'd0)
            dcnt_nxt = dcnt - 8'd1;
        // With DEAD=0 a reload lands directly on zero, giving no gap.
        drive    = Enable && (dcnt_nxt == 8'd0);
    end

    // Counter, edge-detect history and the registered gate outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dcnt  <= DEAD_V;
            raw_q <= 1'b0;
            en_q  <= 1'b0;
            H     <= 1'b0;
            L     <= 1'b0;
        end else begin
            dcnt  <= dcnt_nxt;
            raw_q <= raw;
            en_q  <= Enable;
            H     <= drive &&  raw;
            L     <= drive && !raw;
        end
    end

endmodule

// File: rtl/three_phase_pwm.sv
// Three-phase centre-aligned PWM with dead-time protected gate outputs.
// A triangle carrier 0..MAX..1 is compared with per-phase duty values that
// are captured together at the carrier trough, where Sync also pulses.
// Optional fault latch: define THREE_PHASE_PWM_FAULT_LATCH_EN to add the
// Fault / FaultClear inputs and the Tripped output.
module three_phase_pwm
    import three_phase_pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int DEAD  = DEAD_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Enable,
    input  sample_t               Duty1,
    input  sample_t               Duty2,
    input  sample_t               Duty3,
`ifdef THREE_PHASE_PWM_FAULT_LATCH_EN
    input  logic                  Fault,
    input  logic                  FaultClear,
    output logic                  Tripped,
`endif
    output logic                  Sync,
    output logic [NUM_PHASES-1:0] PwmH,
    output logic [NUM_PHASES-1:0] PwmL
);

    localparam logic [CNT_W-1:0] MAX  = '1;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO = '0;

    logic [CNT_W-1:0]                  cnt;
    logic [CNT_W-1:0]                  cnt_nxt;
    dir_e                              dir;
    dir_e                              dir_nxt;
    sample_t                           duty   [NUM_PHASES];
    logic [NUM_PHASES-1:0][CNT_W-1:0]  cmp;
    logic [NUM_PHASES-1:0][CNT_W-1:0]  shadow;
    logic [NUM_PHASES-1:0]             raw;
    logic                              gate_en;

    assign duty[U] = Duty1;
    assign duty[V] = Duty2;
    assign duty[W] = Duty3;

    // Carrier step: up to the peak, then down to 1 so the trough value 0
    // appears once per period and the period is 2*MAX cycles.
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        if (dir == DIR_UP) begin
            if (cnt == MAX) begin
                cnt_nxt = MAX - ONE;
                dir_nxt = DIR_DOWN;
            end else begin
                cnt_nxt = cnt + ONE;
            end
        end else begin
            cnt_nxt = cnt - ONE;
            if (cnt == ONE)
                dir_nxt = DIR_UP;
        end
    end

    // Carrier state and the trough marker, registered so Sync is aligned
    // with the cycle whose counter is 0 (but is low in reset).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt  <= ZERO;
            dir  <= DIR_UP;
            Sync <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            dir  <= dir_nxt;
            Sync <= (cnt_nxt == ZERO);
        end
    end

    // Duty to compare value: keep the top CNT_W bits of the offset-binary sample.
    for (genvar n = 0; n < NUM_PHASES; n++) begin : g_cmp
        logic [SAMPLE_W-1:0] off;
        assign off    = to_offset(duty[n]);
        assign cmp[n] = CNT_W'(off >> (SAMPLE_W - CNT_W));
    end

    // Shadow capture at the trough and raw comparison against the live shadow.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            shadow <= '0;
            raw    <= '0;
        end else begin
            for (int n = 0; n < NUM_PHASES; n++) begin
                if (cnt == ZERO)
                    shadow[n] <= cmp[n];
                raw[n] <= (cnt < shadow[n]);
            end
        end
    end

`ifdef THREE_PHASE_PWM_FAULT_LATCH_EN
    logic tripped_nxt;

    // Fault wins over clear; the gates see the new trip state on the same edge.
    assign tripped_nxt = Fault | (Tripped & ~FaultClear);
    assign gate_en     = Enable & ~tripped_nxt;

    // Sticky fault latch.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            Tripped <= 1'b0;
        else
            Tripped <= tripped_nxt;
    end
`else
    assign gate_en = Enable;
`endif

    for (genvar n = 0; n < NUM_PHASES; n++) begin : g_leg
        pwm_deadtime #(
            .DEAD (DEAD)
        ) u_dt (
            .Clk    (Clk),
            .Reset  (Reset),
            .Enable (gate_en),
            .raw    (raw[n]),
            .H      (PwmH[n]),
            .L      (PwmL[n])
        );
    end

endmodule
